pc_opponent: RTL and testbench
==============================

PC_OPPONENT -- requirements
Module: pc_opponent

Interface
REQ-001 Parameter: LFSR_SEED, default 16'hACE1, nonzero reset value of the internal 16-bit LFSR.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-004 place_start  input  1  one-cycle pulse; begin new game and place PC ships.
REQ-005 ship_count  input  3  number of PC ships (single-cell), sampled on place_start.
REQ-006 turn_start  input  1  one-cycle pulse; PC must fire one shot at the player board.
REQ-007 player_board  input  25  player ship map, bit index = row*5+col, 1 = ship.
REQ-008 pc_board  output  25  PC ship map, same indexing.
REQ-009 placing_done  output  1  high once all PC ships are placed; held until next place_start or reset.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 shot_valid  output  1  one-cycle pulse; shot_row, shot_col and shot_hit are valid.
REQ-012 shot_row  output  3  fired row, 0..4.
REQ-013 shot_col  output  3  fired column, 0..4.
REQ-014 shot_hit  output  1  player_board bit at the fired cell, sampled in the FIRE cycle.
REQ-015 all_fired  output  1  high when all 25 cells have been fired at.

Function
REQ-016 LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400), advances every cycle while rst=1.
REQ-017 Candidate index = lfsr[4:0]; a value >= 25 is rejected and a new pick happens next cycle.
REQ-018 FSM states: IDLE, PLACE_PICK, PLACE_CHECK, SHOOT_PICK, SHOOT_CHECK, FIRE.
REQ-019 IDLE + place_start: clear pc_board, fired mask, placing_done, all_fired; latch clamped count; go to PLACE_PICK.
REQ-020 Count clamp: ship_count 0 -> 1; values > 5 -> 5; 1..5 pass unchanged.
REQ-021 PLACE_PICK: latch candidate; go to PLACE_CHECK.
REQ-022 PLACE_CHECK: if the candidate is < 25 and its pc_board bit is 0, set the bit and decrement remaining; return to PLACE_PICK if remaining > 0, else assert placing_done and go to IDLE.
REQ-023 PLACE_CHECK on reject: return to PLACE_PICK with no board change.
REQ-024 IDLE + turn_start with placing_done=1 and all_fired=0: go to SHOOT_PICK and clear the attempt counter.
REQ-025 SHOOT_PICK/SHOOT_CHECK: accept a candidate < 25 whose fired-mask bit is 0, then go to FIRE; on reject, increment the attempt counter and pick again.
REQ-026 Starvation guard: after 8 rejects, the lowest-index unfired cell is chosen deterministically.
REQ-027 FIRE: set the fired bit; pulse shot_valid with row = idx/5, col = idx%5, shot_hit = player_board[idx]; set all_fired if all 25 bits are set; go to IDLE.
REQ-028 Latency: shot_valid occurs 3 to 20 cycles after turn_start; exactly one pulse per accepted turn.
REQ-029 place_start and turn_start in the same IDLE cycle: place_start wins and turn_start is dropped.
REQ-030 Both pulses are ignored while busy=1.
REQ-031 turn_start is ignored when placing_done=0 or all_fired=1.
REQ-032 shot_row, shot_col and shot_hit hold their last values between pulses.

Reset
REQ-033 rst=0 forces state IDLE, lfsr=LFSR_SEED, and clears pc_board, fired mask and counters.
REQ-034 rst=0 forces placing_done, busy, shot_valid, shot_hit and all_fired to 0, and shot_row and shot_col to 0.
REQ-035 Reset mid-placement or mid-shot aborts without any shot_valid pulse; the block is in IDLE on the first edge after release.

Verification
REQ-036 Reset release, place_start with ship_count=3 -> placing_done rises, popcount(pc_board)=3, busy falls with it.
REQ-037 ship_count=0 -> exactly 1 ship; ship_count=7 -> exactly 5 ships; no duplicate cells in either case.
REQ-038 player_board=25'h1FFFFFF, 25 turn_starts -> 25 shot_valid pulses, all shot_hit=1, 25 distinct (row,col) pairs, all_fired=1 after the last; a 26th turn_start gives no pulse.
REQ-039 player_board=0, one turn -> shot_hit=0, row<5, col<5, pulse within 3..20 cycles of turn_start.
REQ-040 place_start and turn_start pulsed in the same cycle -> placement runs and no shot_valid occurs; turn_start during busy -> ignored.
REQ-041 rst=0 asserted mid-PLACE_PICK -> all outputs cleared asynchronously; a later place_start completes normally.

Source files
------------

// File: rtl/pc_opponent.sv
// pc_opponent -- computer opponent for a 5x5 single-cell battleship game.
//
// Places 1..5 ships on its own board using a free-running 16-bit Galois
// LFSR. On each accepted turn it fires at one cell of the player board that
// it has not yet fired at.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   place_start   pulse: start a new game and place the PC ships
//   ship_count    number of PC ships, sampled with place_start (clamped 1..5)
//   turn_start    pulse: fire one shot at the player board
//   player_board  player ship map, bit row*5+col
//   pc_board      PC ship map, bit row*5+col
//   placing_done  all PC ships placed; held until next place_start / reset
//   busy          FSM not in IDLE
//   shot_valid    one-cycle pulse qualifying shot_row/shot_col/shot_hit
//   shot_row      fired row 0..4, held between pulses
//   shot_col      fired column 0..4, held between pulses
//   shot_hit      player_board bit at the fired cell
//   all_fired     every one of the 25 cells has been fired at
module pc_opponent #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        place_start,
    input  logic [2:0]  ship_count,
    input  logic        turn_start,
    input  logic [24:0] player_board,
    output logic [24:0] pc_board,
    output logic        placing_done,
    output logic        busy,
    output logic        shot_valid,
    output logic [2:0]  shot_row,
    output logic [2:0]  shot_col,
    output logic        shot_hit,
    output logic        all_fired
);

    typedef enum logic [2:0] {
        IDLE,
        PLACE_PICK,
        PLACE_CHECK,
        SHOOT_PICK,
        SHOOT_CHECK,
        FIRE
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [24:0] board_q;
    logic [24:0] fired_q;
    logic [2:0]  remain_q;
    logic [3:0]  attempts_q;
    logic [4:0]  cand_q;
    logic        done_q;
    logic        all_fired_q;
    logic        shot_valid_q;
    logic [2:0]  row_q, col_q;
    logic        hit_q;

    logic [2:0]  count_d;
    logic [4:0]  lowest_d;
    logic [24:0] fired_set_d;

    function automatic logic [2:0] row_of(input logic [4:0] idx);
        return 3'(idx / 5'd5);
    endfunction

    function automatic logic [2:0] col_of(input logic [4:0] idx);
        return 3'(idx % 5'd5);
    endfunction

    // Galois form: shift right, fold the mask in when a 1 falls out.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    always_comb begin
        count_d = ship_count;
        if (ship_count == 3'd0)
            count_d = 3'd1;
        else if (ship_count > 3'd5)
            count_d = 3'd5;
    end

    // Lowest unfired cell, used once random picks have been rejected too
    // often. Descending scan so the smallest index wins.
    always_comb begin
        lowest_d = 5'd0;
        for (int i = 24; i >= 0; i--) begin
            if (!fired_q[i])
                lowest_d = 5'(i);
        end
    end

    always_comb begin
        fired_set_d = fired_q | (25'd1 << cand_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            board_q      <= '0;
            fired_q      <= '0;
            remain_q     <= '0;
            attempts_q   <= '0;
            cand_q       <= '0;
            done_q       <= 1'b0;
            all_fired_q  <= 1'b0;
            shot_valid_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            hit_q        <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            shot_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // place_start has priority over a simultaneous turn_start.
                    if (place_start) begin
                        board_q     <= '0;
                        fired_q     <= '0;
                        done_q      <= 1'b0;
                        all_fired_q <= 1'b0;
                        remain_q    <= count_d;
                        state_q     <= PLACE_PICK;
                    end else if (turn_start && done_q && !all_fired_q) begin
                        attempts_q <= '0;
                        state_q    <= SHOOT_PICK;
                    end
                end
                PLACE_PICK: begin
                    cand_q  <= lfsr_q[4:0];
                    state_q <= PLACE_CHECK;
                end
                PLACE_CHECK: begin
                    if (cand_q < 5'd25 && !board_q[cand_q]) begin
                        board_q[cand_q] <= 1'b1;
                        remain_q        <= remain_q - 3'd1;
                        if (remain_q == 3'd1) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= PLACE_PICK;
                        end
                    end else begin
                        state_q <= PLACE_PICK;
                    end
                end
                SHOOT_PICK: begin
                    cand_q  <= (attempts_q >= 4'd8) ? lowest_d : lfsr_q[4:0];
                    state_q <= SHOOT_CHECK;
                end
                SHOOT_CHECK: begin
                    if (cand_q < 5'd25 && !fired_q[cand_q]) begin
                        state_q <= FIRE;
                    end else begin
                        attempts_q <= attempts_q + 4'd1;
                        state_q    <= SHOOT_PICK;
                    end
                end
                FIRE: begin
                    fired_q      <= fired_set_d;
                    shot_valid_q <= 1'b1;
                    row_q        <= row_of(cand_q);
                    col_q        <= col_of(cand_q);
                    hit_q        <= player_board[cand_q];
                    all_fired_q  <= &fired_set_d;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_board     = board_q;
    assign placing_done = done_q;
    assign busy         = (state_q != IDLE);
    assign shot_valid   = shot_valid_q;
    assign shot_row     = row_q;
    assign shot_col     = col_q;
    assign shot_hit     = hit_q;
    assign all_fired    = all_fired_q;

endmodule

// File: tb/tb_pc_opponent.sv
module tb_pc_opponent;

    logic        clk;
    logic        rst;
    logic        place_start;
    logic [2:0]  ship_count;
    logic        turn_start;
    logic [24:0] player_board;
    logic [24:0] pc_board;
    logic        placing_done;
    logic        busy;
    logic        shot_valid;
    logic [2:0]  shot_row;
    logic [2:0]  shot_col;
    logic        shot_hit;
    logic        all_fired;

    int n_cmp;
    int n_bad;

    pc_opponent #(.LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst          (rst),
        .place_start  (place_start),
        .ship_count   (ship_count),
        .turn_start   (turn_start),
        .player_board (player_board),
        .pc_board     (pc_board),
        .placing_done (placing_done),
        .busy         (busy),
        .shot_valid   (shot_valid),
        .shot_row     (shot_row),
        .shot_col     (shot_col),
        .shot_hit     (shot_hit),
        .all_fired    (all_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse turn_start for one cycle and wait (bounded) for a shot.
    // lat = number of rising edges after the one that sampled turn_start.
    task automatic do_turn(output bit got, output int lat,
                           output logic [2:0] r, output logic [2:0] c,
                           output logic h);
        got = 0; lat = 0; r = '0; c = '0; h = 1'b0;
        turn_start = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) turn_start = 1'b0;
            if (shot_valid) begin
                got = 1; lat = k - 1;
                r = shot_row; c = shot_col; h = shot_hit;
            end
        end
        turn_start = 1'b0;
    endtask

    // Pulse place_start and wait (bounded) for placing_done.
    task automatic do_place(input logic [2:0] cnt, output bit ok,
                            output logic busy_at_done, output bit shot_seen);
        ok = 0; busy_at_done = 1'b1; shot_seen = 0;
        ship_count  = cnt;
        place_start = 1'b1;
        for (int k = 1; k <= 2000 && !ok; k++) begin
            @(negedge clk);
            if (k == 1) place_start = 1'b0;
            if (shot_valid) shot_seen = 1;
            if (placing_done) begin
                ok = 1; busy_at_done = busy;
            end
        end
        place_start = 1'b0;
    endtask

    task automatic test_reset();
        bit got; int lat; logic [2:0] r, c; logic h;
        repeat (3) @(negedge clk);
        n_cmp++; if (pc_board !== 25'd0) begin n_bad++; $display("FAIL rst_pc_board: got %h want 0", pc_board); end
        n_cmp++; if (placing_done !== 1'b0) begin n_bad++; $display("FAIL rst_placing_done: got %b want 0", placing_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (shot_valid !== 1'b0) begin n_bad++; $display("FAIL rst_shot_valid: got %b want 0", shot_valid); end
        n_cmp++; if ({shot_row, shot_col, shot_hit, all_fired} !== 8'd0) begin n_bad++; $display("FAIL rst_shot_fields: got row %0d col %0d hit %b all %b want zeros", shot_row, shot_col, shot_hit, all_fired); end
        rst = 1'b1;
        @(negedge clk);
        // No placement yet: a turn must be ignored.
        do_turn(got, lat, r, c, h);
        n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL turn_before_place: got pulse %b want 0", got); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL turn_before_place_busy: got %b want 0", busy); end
    endtask

    task automatic test_place3();
        bit ok, ss; logic bd;
        do_place(3'd3, ok, bd, ss);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL place3_done: got %b want 1", ok); end
        n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL place3_busy_at_done: got %b want 0", bd); end
        n_cmp++; if ($countones(pc_board) != 3) begin n_bad++; $display("FAIL place3_pop: got %0d want 3", $countones(pc_board)); end
        n_cmp++; if (ss !== 1'b0) begin n_bad++; $display("FAIL place3_no_shot: got %b want 0", ss); end
    endtask

    task automatic test_clamp();
        bit ok, ss; logic bd;
        logic [2:0] cnts [3] = '{3'd0, 3'd7, 3'd5};
        int         want [3] = '{1, 5, 5};
        for (int i = 0; i < 3; i++) begin
            do_place(cnts[i], ok, bd, ss);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL clamp_done[%0d]: got %b want 1", cnts[i], ok); end
            n_cmp++; if ($countones(pc_board) != want[i]) begin n_bad++; $display("FAIL clamp_pop[%0d]: got %0d want %0d", cnts[i], $countones(pc_board), want[i]); end
        end
    endtask

    task automatic test_single_shot();
        bit got; int lat; logic [2:0] r, c; logic h;
        player_board = 25'd0;
        do_turn(got, lat, r, c, h);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %b want 1", got); end
        n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL single_hit: got %b want 0", h); end
        n_cmp++; if (r > 3'd4 || c > 3'd4) begin n_bad++; $display("FAIL single_range: got row %0d col %0d want <5", r, c); end
        n_cmp++; if (lat < 3 || lat > 20) begin n_bad++; $display("FAIL single_latency: got %0d want 3..20", lat); end
        @(negedge clk);
        n_cmp++; if (shot_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_pulse: got %b want 0", shot_valid); end
        repeat (4) @(negedge clk);
        n_cmp++; if (shot_row !== r || shot_col !== c) begin n_bad++; $display("FAIL single_hold: got %0d,%0d want %0d,%0d", shot_row, shot_col, r, c); end
    endtask

    // Asymmetric board: a swapped row/col or wrong index shows up as a
    // wrong hit bit.
    task automatic test_pattern();
        bit got; int lat; logic [2:0] r, c; logic h;
        logic [24:0] pat;
        int idx;
        pat = 25'h0A53C96;
        player_board = pat;
        for (int t = 0; t < 6; t++) begin
            do_turn(got, lat, r, c, h);
            n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL pattern_pulse[%0d]: got %b want 1", t, got); end
            idx = int'(r) * 5 + int'(c);
            n_cmp++;
            if (r > 3'd4 || c > 3'd4) begin
                n_bad++; $display("FAIL pattern_range[%0d]: got row %0d col %0d want <5", t, r, c);
            end else if (h !== pat[idx]) begin
                n_bad++; $display("FAIL pattern_hit[%0d]: cell %0d,%0d got %b want %b", t, r, c, h, pat[idx]);
            end
        end
    endtask

    task automatic test_collision();
        bit ok, ss; logic bd;
        // Both pulses together in IDLE with a live game: placement wins.
        ok = 0; ss = 0;
        ship_count = 3'd3; place_start = 1'b1; turn_start = 1'b1;
        for (int k = 1; k <= 2000 && !ok; k++) begin
            @(negedge clk);
            if (k == 1) begin place_start = 1'b0; turn_start = 1'b0; end
            if (shot_valid) ss = 1;
            if (placing_done) ok = 1;
        end
        repeat (25) begin @(negedge clk); if (shot_valid) ss = 1; end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL collide_done: got %b want 1", ok); end
        n_cmp++; if (ss !== 1'b0) begin n_bad++; $display("FAIL collide_no_shot: got %b want 0", ss); end
        n_cmp++; if ($countones(pc_board) != 3) begin n_bad++; $display("FAIL collide_pop: got %0d want 3", $countones(pc_board)); end
        // Pulses while busy are ignored.
        ok = 0; ss = 0;
        ship_count = 3'd2; place_start = 1'b1;
        @(negedge clk);
        place_start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_during_place: got %b want 1", busy); end
        ship_count = 3'd5; place_start = 1'b1; turn_start = 1'b1;
        for (int k = 1; k <= 2000 && !ok; k++) begin
            @(negedge clk);
            if (k == 1) begin place_start = 1'b0; turn_start = 1'b0; end
            if (shot_valid) ss = 1;
            if (placing_done) ok = 1;
        end
        repeat (25) begin @(negedge clk); if (shot_valid) ss = 1; end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_ign_done: got %b want 1", ok); end
        n_cmp++; if ($countones(pc_board) != 2) begin n_bad++; $display("FAIL busy_ign_pop: got %0d want 2", $countones(pc_board)); end
        n_cmp++; if (ss !== 1'b0) begin n_bad++; $display("FAIL busy_ign_no_shot: got %b want 0", ss); end
    endtask

    task automatic test_full_board();
        bit ok, ss, got; logic bd; int lat; logic [2:0] r, c; logic h;
        logic [24:0] seen;
        int idx;
        do_place(3'd4, ok, bd, ss);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL full_place: got %b want 1", ok); end
        player_board = 25'h1FFFFFF;
        seen = '0;
        for (int t = 0; t < 25; t++) begin
            do_turn(got, lat, r, c, h);
            n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL full_pulse[%0d]: got %b want 1", t, got); end
            n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL full_hit[%0d]: got %b want 1", t, h); end
            n_cmp++; if (lat < 3 || lat > 20) begin n_bad++; $display("FAIL full_latency[%0d]: got %0d want 3..20", t, lat); end
            idx = int'(r) * 5 + int'(c);
            n_cmp++;
            if (r > 3'd4 || c > 3'd4) begin
                n_bad++; $display("FAIL full_range[%0d]: got row %0d col %0d want <5", t, r, c);
            end else if (seen[idx]) begin
                n_bad++; $display("FAIL full_distinct[%0d]: cell %0d,%0d repeated, want new cell", t, r, c);
            end else begin
                seen[idx] = 1'b1;
            end
            if (t == 23) begin
                n_cmp++; if (all_fired !== 1'b0) begin n_bad++; $display("FAIL full_all_fired_early: got %b want 0", all_fired); end
            end
        end
        n_cmp++; if (all_fired !== 1'b1) begin n_bad++; $display("FAIL full_all_fired: got %b want 1", all_fired); end
        n_cmp++; if (seen !== 25'h1FFFFFF) begin n_bad++; $display("FAIL full_coverage: got %h want 1ffffff", seen); end
        do_turn(got, lat, r, c, h);
        n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL full_26th: got pulse %b want 0", got); end
    endtask

    task automatic test_reset_mid();
        bit ok, ss; logic bd;
        // Asynchronous reset while idle with a finished game on the board.
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (pc_board !== 25'd0) begin n_bad++; $display("FAIL areset_pc_board: got %h want 0", pc_board); end
        n_cmp++; if (placing_done !== 1'b0 || all_fired !== 1'b0 || shot_hit !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got done %b all %b hit %b want 000", placing_done, all_fired, shot_hit); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Reset while placement is in progress.
        ss = 0;
        ship_count = 3'd5; place_start = 1'b1;
        @(negedge clk);
        place_start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || placing_done !== 1'b0 || shot_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_outputs: got busy %b done %b valid %b want 000", busy, placing_done, shot_valid); end
        n_cmp++; if (pc_board !== 25'd0 || shot_row !== 3'd0 || shot_col !== 3'd0) begin n_bad++; $display("FAIL mid_reset_board: got %h row %0d col %0d want zeros", pc_board, shot_row, shot_col); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin @(negedge clk); if (shot_valid) ss = 1; end
        n_cmp++; if (busy !== 1'b0 || ss !== 1'b0) begin n_bad++; $display("FAIL mid_after_release: got busy %b shot %b want 0 0", busy, ss); end
        do_place(3'd3, ok, bd, ss);
        n_cmp++; if (ok !== 1'b1 || $countones(pc_board) != 3) begin n_bad++; $display("FAIL mid_replace: got done %b pop %0d want 1 3", ok, $countones(pc_board)); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; place_start = 1'b0; turn_start = 1'b0;
        ship_count = 3'd0; player_board = 25'd0;
        test_reset();
        test_place3();
        test_clamp();
        test_single_shot();
        test_pattern();
        test_collision();
        test_full_board();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a bounded wait is ever bypassed.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
